memory_byte_loader: RTL and testbench

- Avalon-MM write master that sits directly upstream of the processor's on-chip 32-bit memory (5120 words, 13-bit word address, byte enables, single-cycle writes, no waitrequest).
- Accepts an 8-bit valid/ready byte stream, for example from a UART or boot channel, and packs it little-endian into 32-bit words.
- Writes the packed words to consecutive word addresses, starting at a programmed base. The final partial word is written with only its valid byte lanes enabled.
- Used to load program and data images into memory while the CPU is held in reset.

---
 rtl/memory_loader_pkg.sv | 15 +
 rtl/byte_packer.sv | 41 ++++
 rtl/memory_byte_loader.sv | 163 ++++++++++++++++
 tb/tb_memory_byte_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_loader_pkg.sv
// rtl/memory_loader_pkg.sv - shared state encoding and word geometry for the byte loader
package memory_loader_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 5120;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian 4-lane word assembler with byte-enable accumulator
module byte_packer
  import memory_loader_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic                      clear,
  input  logic [7:0]                data,
  output logic [WORD_W-1:0]         word,
  output logic [BYTES_PER_WORD-1:0] byteenable,
  output logic                      full
);

  logic [WORD_W-1:0]         word_q;
  logic [BYTES_PER_WORD-1:0] be_q;
  logic [1:0]                lane_idx;

  // clear wins over load so a fresh word never inherits stale lanes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_q   <= '0;
      be_q     <= '0;
      lane_idx <= '0;
    end else if (clear) begin
      word_q   <= '0;
      be_q     <= '0;
      lane_idx <= '0;
    end else if (load) begin
      word_q[{lane_idx, 3'b000} +: 8] <= data;
      be_q[lane_idx]                  <= 1'b1;
      lane_idx                        <= lane_idx + 2'd1;
    end
  end

  assign word       = word_q;
  assign byteenable = be_q;
  // high when the next load lands in the top lane and completes the word
  assign full       = (lane_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/memory_byte_loader.sv
// rtl/memory_byte_loader.sv - byte stream to 32-bit memory write master
// Optional running byte checksum output when LOADER_CHECKSUM_EN is defined.
module memory_byte_loader
  import memory_loader_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [LEN_W-1:0]    byte_count,
  output logic                busy,
  output logic                done,
  output logic                err,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ADDR_W-1:0]   m_address,
  output logic [3:0]          m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [WORD_W-1:0]   m_writedata,
  output logic                m_clken
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]         checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   word_addr;
  logic [LEN_W-1:0]    remaining;
  logic                done_q;
  logic                err_q;
  logic                err_next;
  logic                start_accept;
  logic                addr_inc;
  logic                pk_clear;
  logic                handshake;
  logic [WORD_W-1:0]   pk_word;
  logic [3:0]          pk_be;
  logic                pk_full;

  assign handshake = s_valid && s_ready;

  byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (handshake),
    .clear      (pk_clear),
    .data       (s_data),
    .word       (pk_word),
    .byteenable (pk_be),
    .full       (pk_full)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      word_addr <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= (next_state == FINISH);
      err_q  <= err_next;
      if (start_accept) begin
        word_addr <= start_addr;
      end else if (addr_inc) begin
        word_addr <= word_addr + 1'b1;
      end
      if (start_accept) begin
        remaining <= byte_count;
      end else if (handshake) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

  always_comb begin
    next_state   = state;
    err_next     = 1'b0;
    start_accept = 1'b0;
    addr_inc     = 1'b0;
    pk_clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          pk_clear     = 1'b1;
          // an out-of-range base aborts before any byte is taken
          if (start_addr > LAST_ADDR) begin
            err_next = 1'b1;
          end else if (byte_count == '0) begin
            next_state = FINISH;
          end else begin
            next_state = FILL;
          end
        end
      end
      FILL: begin
        if (handshake && (pk_full || remaining == LEN_W'(1))) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        if (remaining != '0) begin
          if (word_addr == LAST_ADDR) begin
            err_next   = 1'b1;
            next_state = IDLE;
          end else begin
            addr_inc   = 1'b1;
            pk_clear   = 1'b1;
            next_state = FILL;
          end
        end else begin
          next_state = FINISH;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign s_ready      = (state == FILL);
  assign m_write      = (state == WRITE);
  assign m_chipselect = (state == WRITE);
  assign m_address    = word_addr;
  assign m_byteenable = pk_be;
  assign m_writedata  = pk_word;
  assign m_clken      = 1'b1;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (start_accept) begin
      sum_q <= '0;
    end else if (handshake) begin
      sum_q <= sum_q + {8'h00, s_data};
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_memory_byte_loader.sv
// tb/tb_memory_byte_loader.sv - scoreboard bench for memory_byte_loader
module tb_memory_byte_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [12:0] start_addr = '0;
  logic [15:0] byte_count = '0;
  logic        busy, done, err;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [12:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write, m_clken;
  logic [31:0] m_writedata;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  memory_byte_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_addr   (start_addr),
    .byte_count   (byte_count),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_address    (m_address),
    .m_byteenable (m_byteenable),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_clken      (m_clken)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_wr[$];
  logic [1:0] exp_ev[$];
  wr_t  mon_e;
  logic [1:0] mon_k;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int wr_seen = 0, ev_seen = 0, hs_seen = 0, rdy_seen = 0;
  int last_wr_cyc = 0, last_ev_cyc = 0, drive_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT writes or signals an event
  always @(negedge clk) begin
    if (reset_n) begin
      if (s_valid && s_ready) hs_seen++;
      if (s_ready) rdy_seen++;
      if (m_write) begin
        wr_seen++;
        last_wr_cyc = cyc;
        check("wr_chipselect", {31'b0, m_chipselect}, 32'd1);
        if (exp_wr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %h be %b data %h", m_address, m_byteenable, m_writedata);
        end else begin
          mon_e = exp_wr.pop_front();
          check("wr_addr", {19'b0, m_address}, {19'b0, mon_e.addr});
          check("wr_be", {28'b0, m_byteenable}, {28'b0, mon_e.be});
          check("wr_data", m_writedata, mon_e.data);
        end
      end
      if (done || err) begin
        ev_seen++;
        last_ev_cyc = cyc;
        if (exp_ev.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: done %b err %b", done, err);
        end else begin
          mon_k = exp_ev.pop_front();
          check("event_kind", {30'b0, err, done}, {30'b0, mon_k});
        end
      end
    end
  end

  task automatic push_wr(input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.be = be;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic pulse_start(input logic [12:0] a, input logic [15:0] n, input int hold);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = a;
    byte_count = n;
    drive_cyc = cyc;
    repeat (hold) @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data = b;
    t = 0;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        break;
      end
      t++;
      if (t > 50) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: byte %h never accepted", b);
        s_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_ev(input string name, input int base);
    for (int t = 0; t < 200; t++) begin
      if (ev_seen > base) return;
      @(posedge clk);
    end
    tests++;
    fails++;
    $display("FAIL %s: no done/err within budget, got 0 expected 1", name);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_err"}, {31'b0, err}, 32'd0);
    check({tag, "_s_ready"}, {31'b0, s_ready}, 32'd0);
    check({tag, "_m_write"}, {31'b0, m_write}, 32'd0);
    check({tag, "_m_cs"}, {31'b0, m_chipselect}, 32'd0);
    check({tag, "_m_addr"}, {19'b0, m_address}, 32'd0);
    check({tag, "_m_be"}, {28'b0, m_byteenable}, 32'd0);
    check({tag, "_m_wdata"}, m_writedata, 32'd0);
  endtask

  initial begin
    int base, wbase, hbase, rbase;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    check("m_clken", {31'b0, m_clken}, 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // full words, back-to-back
    push_wr(13'h010, 4'b1111, 32'h44332211);
    push_wr(13'h011, 4'b1111, 32'h88776655);
    exp_ev.push_back(2'b01);
    base = ev_seen;
    pulse_start(13'h010, 16'd8, 1);
    for (int i = 1; i <= 8; i++) begin
      b = 8'(i * 8'h11);
      send_byte(b, 0);
    end
    wait_ev("full_wait", base);
    check("full_done_after_write", 32'(last_ev_cyc - last_wr_cyc), 32'd1);
    @(negedge clk);
    check("full_busy_after", {31'b0, busy}, 32'd0);

    // partial final word, with an ignored start while busy
    push_wr(13'h040, 4'b1111, 32'hA3A2A1A0);
    push_wr(13'h041, 4'b0011, 32'h0000A5A4);
    exp_ev.push_back(2'b01);
    base = ev_seen;
    wbase = wr_seen;
    pulse_start(13'h040, 16'd6, 1);
    send_byte(8'hA0, 0);
    send_byte(8'hA1, 0);
    pulse_start(13'h1F0, 16'd0, 1);
    for (int i = 2; i < 6; i++) send_byte(8'hA0 + 8'(i), 0);
    wait_ev("partial_wait", base);
    repeat (5) @(posedge clk);
    check("partial_write_count", 32'(wr_seen - wbase), 32'd2);

    // zero length, start held into the busy cycle
    exp_ev.push_back(2'b01);
    base = ev_seen;
    rbase = rdy_seen;
    wbase = wr_seen;
    pulse_start(13'h005, 16'd0, 2);
    wait_ev("zero_wait", base);
    repeat (6) @(posedge clk);
    check("zero_done_latency", 32'(last_ev_cyc + 1 - drive_cyc), 32'd2);
    check("zero_done_count", 32'(ev_seen - base), 32'd1);
    check("zero_s_ready", 32'(rdy_seen - rbase), 32'd0);
    check("zero_no_write", 32'(wr_seen - wbase), 32'd0);

    // overflow at the last word
    push_wr(13'd5119, 4'b1111, 32'hC3C2C1C0);
    exp_ev.push_back(2'b10);
    base = ev_seen;
    wbase = wr_seen;
    hbase = hs_seen;
    pulse_start(13'd5119, 16'd5, 1);
    for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 0);
    s_valid = 1'b1;
    s_data = 8'hC4;
    repeat (8) @(posedge clk);
    #1 s_valid = 1'b0;
    wait_ev("ovf_wait", base);
    check("ovf_handshakes", 32'(hs_seen - hbase), 32'd4);
    check("ovf_writes", 32'(wr_seen - wbase), 32'd1);
    check("ovf_err_after_write", 32'(last_ev_cyc - last_wr_cyc), 32'd1);

    // base beyond the last word
    exp_ev.push_back(2'b10);
    base = ev_seen;
    wbase = wr_seen;
    pulse_start(13'd5120, 16'd4, 1);
    wait_ev("badaddr_wait", base);
    repeat (4) @(posedge clk);
    check("badaddr_err_latency", 32'(last_ev_cyc + 1 - drive_cyc), 32'd2);
    check("badaddr_no_write", 32'(wr_seen - wbase), 32'd0);

    // random producer stalls
    push_wr(13'h100, 4'b1111, 32'h04030201);
    push_wr(13'h101, 4'b1111, 32'h08070605);
    push_wr(13'h102, 4'b0001, 32'h00000009);
    exp_ev.push_back(2'b01);
    base = ev_seen;
    pulse_start(13'h100, 16'd9, 1);
    for (int i = 1; i <= 9; i++) send_byte(8'(i), int'($urandom_range(0, 3)));
    wait_ev("bp_wait", base);

    // reset in the middle of FILL
    wbase = wr_seen;
    base = ev_seen;
    pulse_start(13'h200, 16'd8, 1);
    send_byte(8'h51, 0);
    send_byte(8'h52, 0);
    #1 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_quiet("midreset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    check("midreset_no_write", 32'(wr_seen - wbase), 32'd0);
    check("midreset_no_event", 32'(ev_seen - base), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    push_wr(13'h030, 4'b1111, 32'hFFFFFFFF);
    exp_ev.push_back(2'b01);
    base = ev_seen;
    pulse_start(13'h030, 16'd4, 1);
    for (int i = 0; i < 4; i++) send_byte(8'hFF, 0);
    wait_ev("csum_wait", base);
    repeat (3) @(posedge clk);
    check("csum_after_done", {16'b0, checksum}, 32'h03FC);
    push_wr(13'h031, 4'b1111, 32'h01010101);
    exp_ev.push_back(2'b01);
    base = ev_seen;
    pulse_start(13'h031, 16'd4, 1);
    check("csum_cleared", {16'b0, checksum}, 32'h0);
    for (int i = 0; i < 4; i++) send_byte(8'h01, 0);
    wait_ev("csum2_wait", base);
    repeat (2) @(posedge clk);
    check("csum_second", {16'b0, checksum}, 32'h0004);
`endif

    repeat (3) @(posedge clk);
    check("pending_writes", 32'(exp_wr.size()), 32'd0);
    check("pending_events", 32'(exp_ev.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
